// File: rtl/load_store_unit.sv
// Purpose: RV32I load/store engine between a request port and a single-port word-wide data memory.
// Latency: loads and SW respond 2 cycles after accept, SB/SH 3 cycles (read-modify-write), errors 1 cycle.
// Backpressure: req_ready only in IDLE, one request in flight; resp_valid is a one-cycle pulse with no backpressure.
module load_store_unit #(
    parameter int width     = 32,
    parameter int addrWidth = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [width-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [width-1:0]     resp_rdata,
    output logic                 resp_err,
    output logic [addrWidth-1:0] mem_addr,
    output logic [width-1:0]     mem_din,
    output logic                 mem_wren,
    input  logic [width-1:0]     mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Captured request; only the address bits that reach the memory are kept.
    typedef struct packed {
        logic                 write;
        logic [2:0]           funct3;
        logic [addrWidth+1:0] addr;
        logic [width-1:0]     wdata;
        logic                 err;
    } req_t;

    state_t           state, state_nxt;
    req_t             req_q;
    logic [width-1:0] data_q;      // extended load data, or merged word for SB/SH
    logic             req_err;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [width-1:0] load_ext;
    logic [width-1:0] merged;
    logic             sub_word_store;

    // Upper address bits wrap the word index away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:addrWidth+2];

    // Classify the incoming request as misaligned or illegal before it is accepted.
    always_comb begin
        req_err = 1'b1;
        case (req_funct3)
            3'b000:         req_err = 1'b0;
            3'b001:         req_err = req_addr[0];
            3'b010:         req_err = |req_addr[1:0];
            3'b100, 3'b101: req_err = req_write | (req_funct3[0] & req_addr[0]);
            default:        req_err = 1'b1;
        endcase
    end

    // Pick the addressed little-endian lanes out of the memory word.
    always_comb begin
        byte_lane = mem_dout[7:0];
        case (req_q.addr[1:0])
            2'd0: byte_lane = mem_dout[7:0];
            2'd1: byte_lane = mem_dout[15:8];
            2'd2: byte_lane = mem_dout[23:16];
            2'd3: byte_lane = mem_dout[31:24];
            default: byte_lane = mem_dout[7:0];
        endcase
        half_lane = req_q.addr[1] ? mem_dout[31:16] : mem_dout[15:0];
    end

    // Sign- or zero-extend the selected lane for loads.
    always_comb begin
        load_ext = mem_dout;
        case (req_q.funct3)
            3'b000:  load_ext = {{(width-8){byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{(width-16){half_lane[15]}}, half_lane};
            3'b100:  load_ext = {{(width-8){1'b0}}, byte_lane};
            3'b101:  load_ext = {{(width-16){1'b0}}, half_lane};
            default: load_ext = mem_dout;
        endcase
    end

    // Splice store data into the current memory word for SB/SH.
    always_comb begin
        merged = mem_dout;
        if (req_q.funct3[0] == 1'b0) begin
            case (req_q.addr[1:0])
                2'd0: merged[7:0]   = req_q.wdata[7:0];
                2'd1: merged[15:8]  = req_q.wdata[7:0];
                2'd2: merged[23:16] = req_q.wdata[7:0];
                2'd3: merged[31:24] = req_q.wdata[7:0];
                default: merged = mem_dout;
            endcase
        end else if (req_q.addr[1]) begin
            merged[31:16] = req_q.wdata[15:0];
        end else begin
            merged[15:0] = req_q.wdata[15:0];
        end
    end

    assign sub_word_store = req_q.write && (req_q.funct3[1:0] != 2'b10);

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Capture the request on acceptance; inputs are ignored while busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q <= '0;
        end else if (state == IDLE && req_valid) begin
            req_q.write  <= req_write;
            req_q.funct3 <= req_funct3;
            req_q.addr   <= req_addr[addrWidth+1:0];
            req_q.wdata  <= req_wdata;
            req_q.err    <= req_err;
        end
    end

    // Register the load result or the merged store word during the memory access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (state == ACCESS) begin
            data_q <= req_q.write ? merged : load_ext;
        end
    end

    // Next-state and state-decoded outputs so reset drops mem_wren at once.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_addr   = '0;
        mem_din    = '0;
        mem_wren   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_addr = req_q.addr[addrWidth+1:2];
                if (req_q.write && !sub_word_store) begin
                    mem_wren = 1'b1;
                    mem_din  = req_q.wdata;
                end
                state_nxt = sub_word_store ? WRITE : DONE;
            end
            WRITE: begin
                mem_addr  = req_q.addr[addrWidth+1:2];
                mem_wren  = 1'b1;
                mem_din   = data_q;
                state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = req_q.err;
                if (!req_q.write && !req_q.err) resp_rdata = data_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: directed bench for load_store_unit with a word memory model and a response scoreboard.
// Latency: response arrival cycle is checked against the expected offset from the accept cycle.
// Backpressure: requests are issued only when req_ready is seen high; all waits are bounded.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wren;
    logic [31:0] mem_dout;

    logic        preload = 1'b1;
    logic [31:0] mem [0:255];

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        string       tag;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] din;
    } wr_t;

    resp_t sb_q[$];
    wr_t   wr_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_n = 0;

    load_store_unit #(.width(32), .addrWidth(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_wren   (mem_wren),
        .mem_dout   (mem_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Word memory: combinational read, write on rising edge.
    assign mem_dout = mem[mem_addr];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= {4{8'(i)}};
            mem[0] <= 32'h0000_0005;
            mem[1] <= 32'h8000_80F0;
            mem[2] <= 32'h1122_3344;
            mem[3] <= 32'h0000_0000;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Record write strobes and score responses away from the active edge.
    always @(negedge clock) begin
        resp_t e;
        if (mem_wren) wr_q.push_back('{cyc, mem_addr, mem_din});
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {31'b0, resp_valid}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_rdata"}, resp_rdata, e.rdata);
                check({e.tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive one request; lat = 0 means no response is expected.
    task automatic issue(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rdata, input int lat);
        resp_t e;
        @(negedge clock);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
        last_n = cyc;
        if (lat > 0) begin
            e.cyc   = cyc + lat;
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.tag   = tag;
            sb_q.push_back(e);
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clock);
        if (sb_q.size() != 0) begin
            check({tag, "_timeout"}, 32'(sb_q.size()), 32'h0);
            sb_q.delete();
        end
    endtask

    task automatic check_writes(input string tag, input int n, input int off,
                                input logic [7:0] addr, input logic [31:0] din);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(n));
        if (n == 1 && wr_q.size() == 1) begin
            check({tag, "_wr_cycle"}, 32'(wr_q[0].cyc), 32'(last_n + off));
            check({tag, "_wr_addr"}, 32'(wr_q[0].addr), 32'(addr));
            check({tag, "_wr_din"}, wr_q[0].din, din);
        end
        wr_q.delete();
    endtask

    task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rdata, input int lat,
                       input int nwr, input int wr_off, input logic [7:0] wr_addr,
                       input logic [31:0] wr_din);
        issue(tag, wr, f3, addr, wd, exp_err, exp_rdata, lat);
        wait_done(tag);
        check_writes(tag, nwr, wr_off, wr_addr, wr_din);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and preload memory.
        @(posedge clock);
        @(posedge clock);
        preload = 1'b0;
        @(negedge clock);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_err",   {31'b0, resp_err},   32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_mem_wren",   {31'b0, mem_wren},   32'h0);
        check("rst_mem_din",    mem_din,             32'h0);
        check("rst_mem_addr",   32'(mem_addr),       32'h0);
        check("rst_req_ready",  {31'b0, req_ready},  32'h1);
        reset = 1'b0;
        wr_q.delete();

        // Loads from word1 = 0x800080F0.
        txn("lb_4",   1'b0, 3'b000, 32'h4, 32'h0, 1'b0, 32'hFFFF_FFF0, 2, 0, 0, 8'h0, 32'h0);
        txn("lbu_5",  1'b0, 3'b100, 32'h5, 32'h0, 1'b0, 32'h0000_0080, 2, 0, 0, 8'h0, 32'h0);
        txn("lh_6",   1'b0, 3'b001, 32'h6, 32'h0, 1'b0, 32'hFFFF_8000, 2, 0, 0, 8'h0, 32'h0);
        txn("lhu_6",  1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 32'h0000_8000, 2, 0, 0, 8'h0, 32'h0);
        txn("lb_7",   1'b0, 3'b000, 32'h7, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, 0, 8'h0, 32'h0);

        // Sub-word stores: read-modify-write, then read back.
        txn("sb_9",   1'b1, 3'b000, 32'h9, 32'h0000_00AB, 1'b0, 32'h0, 3, 1, 2, 8'd2, 32'h1122_AB44);
        txn("lw_8",   1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'h1122_AB44, 2, 0, 0, 8'h0, 32'h0);
        txn("sh_12",  1'b1, 3'b001, 32'h12, 32'h1234_CAFE, 1'b0, 32'h0, 3, 1, 2, 8'd4, 32'hCAFE_0404);
        txn("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hCAFE_0404, 2, 0, 0, 8'h0, 32'h0);

        // Word store then word load.
        txn("sw_c",   1'b1, 3'b010, 32'hC, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 1, 8'd3, 32'hDEAD_BEEF);
        txn("lw_c",   1'b0, 3'b010, 32'hC, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 0, 8'h0, 32'h0);

        // Misaligned and illegal requests.
        txn("lw_2",   1'b0, 3'b010, 32'h2, 32'h0, 1'b1, 32'h0, 1, 0, 0, 8'h0, 32'h0);
        txn("sh_5",   1'b1, 3'b001, 32'h5, 32'h0000_FFFF, 1'b1, 32'h0, 1, 0, 0, 8'h0, 32'h0);
        txn("ld_011", 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 0, 8'h0, 32'h0);
        txn("st_100", 1'b1, 3'b100, 32'h0, 32'h0000_00FF, 1'b1, 32'h0, 1, 0, 0, 8'h0, 32'h0);
        txn("sw_2",   1'b1, 3'b010, 32'h2, 32'h1234_5678, 1'b1, 32'h0, 1, 0, 0, 8'h0, 32'h0);

        // Reset while SH 0x0 is in its WRITE cycle.
        issue("sh_0_rst", 1'b1, 3'b001, 32'h0, 32'h0000_FFFF, 1'b0, 32'h0, 0);
        check("sh_0_access_wren", {31'b0, mem_wren}, 32'h0);
        @(posedge clock);
        #1;
        check("sh_0_write_wren", {31'b0, mem_wren}, 32'h1);
        check("sh_0_write_din",  mem_din,           32'h0000_FFFF);
        reset = 1'b1;
        #1;
        check("sh_0_rst_wren",  {31'b0, mem_wren},  32'h0);
        check("sh_0_rst_ready", {31'b0, req_ready}, 32'h1);
        check("sh_0_rst_din",   mem_din,            32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("sh_0_word0", mem[0], 32'h0000_0005);
        check_writes("sh_0_rst", 0, 0, 8'h0, 32'h0);
        txn("lw_0",   1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0000_0005, 2, 0, 0, 8'h0, 32'h0);

        // Word index wraps modulo 2**addrWidth.
        issue("lw_400", 1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 32'h0000_0005, 2);
        check("lw_400_mem_addr", 32'(mem_addr), 32'h0);
        wait_done("lw_400");
        check_writes("lw_400", 0, 0, 8'h0, 32'h0);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter width, default 32, data word width in bits (only 32 supported).
REQ-002 SHALL have parameter addrWidth, default 8, data-memory word-address width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  width  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  width  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal request, valid with resp_valid.
REQ-014 SHALL have port mem_addr  output  addrWidth  data-memory word address.
REQ-015 SHALL have port mem_din  output  width  data-memory write data.
REQ-016 SHALL have port mem_wren  output  1  data-memory write enable.
REQ-017 SHALL have port mem_dout  input  width  data-memory combinational read data for mem_addr.

Function
REQ-018 SHALL implement states IDLE, ACCESS, WRITE, DONE; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request when req_valid & req_ready at an edge, capturing write, funct3, addr, wdata.
REQ-020 SHALL flag an error if: H/HU with addr[0]=1; W with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-021 SHALL on an accepted error request go IDLE->DONE, never assert mem_wren, and give resp_valid=1, resp_err=1, resp_rdata=0 in cycle N+1 (N = accept cycle).
REQ-022 SHALL drive mem_addr = captured addr[addrWidth+1:2] in ACCESS and WRITE; upper address bits are ignored (word index wraps modulo 2**addrWidth).
REQ-023 SHALL use little-endian lanes: byte k = bits [8k+7:8k], halfword at addr[1]*16.
REQ-024 SHALL for loads in ACCESS select the addressed lane of mem_dout, sign-extend (B,H) or zero-extend (BU,HU), register it, and pulse resp_valid in N+2 from DONE.
REQ-025 SHALL for SW assert mem_wren=1, mem_din=wdata for exactly the ACCESS cycle (N+1); resp_valid in N+2.
REQ-026 SHALL for SB/SH keep mem_wren=0 in ACCESS, register mem_dout with the addressed lane replaced by wdata[7:0]/wdata[15:0], then in WRITE (N+2) assert mem_wren=1 with mem_din = merged word; resp_valid in N+3.
REQ-027 SHALL assert mem_wren only in ACCESS (SW) or WRITE (SB/SH), decoded from state so reset deasserts it immediately.
REQ-028 SHALL return DONE->IDLE unconditionally; resp_valid has no backpressure; next request earliest accepted one cycle after DONE.
REQ-029 SHALL drive mem_din=0 and resp_rdata=0 whenever not otherwise specified.
REQ-030 SHALL ignore req inputs outside IDLE.

Reset
REQ-031 SHALL on reset asynchronously enter IDLE with resp_valid=0, resp_err=0, resp_rdata=0, mem_wren=0, mem_din=0, mem_addr=0, req_ready=1.
REQ-032 SHALL abandon any in-flight request on reset: no write, no response.

Verification
REQ-033 SHALL cover loads: word1=0x800080F0; LB 0x4 -> 0xFFFFFFF0, LBU 0x5 -> 0x00000080, LH 0x6 -> 0xFFFF8000, each with resp_valid at N+2.
REQ-034 SHALL cover SB: word2=0x11223344; SB 0x9 wdata 0xAB -> single mem_wren pulse at N+2, mem_din 0x1122AB44, resp_valid at N+3.
REQ-035 SHALL cover SW then LW: SW 0xC wdata 0xDEADBEEF -> mem_wren at N+1 addr 3; subsequent LW 0xC -> 0xDEADBEEF.
REQ-036 SHALL cover errors: LW 0x2 and SH 0x5 -> resp_err=1, resp_rdata=0 at N+1, no mem_wren.
REQ-037 SHALL cover reset in WRITE of SH 0x0 -> mem_wren falls same cycle, word 0 unchanged (0x00000005), no resp_valid, req_ready=1.
REQ-038 SHALL cover wrap: addrWidth=8, LW 0x400 -> mem_addr 0, returns word 0.
